// File: rtl/black_level_corr.sv
// Raw-Bayer black-level correction: measures the optically-black lines at the top of
// each frame, IIR-filters that level across frames and subtracts it from every pixel.
module black_level_corr #(
   parameter int          H_ACTIVE   = 1920,
   parameter int          OB_LINES   = 4,
   parameter int          OB_PIX     = 256,
   parameter int          SHIFT      = 10,
   parameter int          FILT_SHIFT = 2,
   parameter logic [11:0] DEFAULT_BL = 12'd64,
   parameter logic [11:0] BL_MAX     = 12'd512
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [11:0] data_in,
   input  logic        fv_in,
   input  logic        lv_in,
   output logic [11:0] data_out,
   output logic        fv_out,
   output logic        lv_out,
   output logic [11:0] bl_value,
   output logic        bl_valid
);

   // a line can never supply more OB samples than it has pixels
   localparam int OB_N   = (OB_PIX < H_ACTIVE) ? OB_PIX : H_ACTIVE;
   localparam int PIX_W  = $clog2(OB_N + 1);
   localparam int LINE_W = $clog2(OB_LINES + 1);
   localparam int ACC_W  = 22;

   typedef enum logic [1:0] {WAIT_FV, OB_LINE, ACTIVE, UPDATE} state_t;

   state_t             state_q, state_d;
   logic [11:0]        data_s1_q, data_s1_d;
   logic               fv_s1_q, fv_s1_d, lv_s1_q, lv_s1_d;
   logic               prime_q, prime_d;
   logic [11:0]        data_out_q, data_out_d;
   logic               fv_out_q, fv_out_d, lv_out_q, lv_out_d;
   logic [11:0]        bl_q, bl_d;
   logic               bl_valid_q, bl_valid_d;
   logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
   logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               armed_q, armed_d;
   logic               meas_ok_q, meas_ok_d;
   logic               short_q, short_d;
   logic               line_ob_q, line_ob_d;

   logic               fv_rise, fv_fall, lv_rise, lv_fall;
   logic               short_now;
   logic [12:0]        px_diff;
   logic [ACC_W-1:0]   meas_full;
   logic [11:0]        meas;
   logic signed [12:0] bl_diff, bl_step, bl_new;

   // stage-1 copies are meaningless on the first cycle out of reset, so edges wait for them
   assign fv_rise = prime_q &  fv_in & ~fv_s1_q;
   assign fv_fall = prime_q & ~fv_in &  fv_s1_q;
   assign lv_rise = prime_q &  lv_in & ~lv_s1_q;
   assign lv_fall = prime_q & ~lv_in &  lv_s1_q;

   always_comb begin
      state_d    = state_q;
      line_cnt_d = line_cnt_q;
      pix_cnt_d  = pix_cnt_q;
      acc_d      = acc_q;
      armed_d    = armed_q;
      meas_ok_d  = meas_ok_q;
      short_d    = short_q;
      line_ob_d  = line_ob_q;
      bl_d       = bl_q;
      bl_valid_d = bl_valid_q;
      short_now  = short_q;

      data_s1_d = data_in;
      fv_s1_d   = fv_in;
      lv_s1_d   = lv_in;
      prime_d   = 1'b1;

      px_diff    = {1'b0, data_s1_q} - {1'b0, bl_q};
      data_out_d = px_diff[12] ? 12'd0 : px_diff[11:0];
      fv_out_d   = fv_s1_q & armed_q;
      lv_out_d   = lv_s1_q & armed_q & ~line_ob_q;

      meas_full = acc_q >> SHIFT;
      meas      = (meas_full > ACC_W'(BL_MAX)) ? BL_MAX : meas_full[11:0];
      bl_diff   = $signed({1'b0, meas}) - $signed({1'b0, bl_q});
      bl_step   = bl_diff >>> FILT_SHIFT;
      bl_new    = $signed({1'b0, bl_q}) + bl_step;

      // a line that opens together with the frame is still an OB line
      if (lv_rise)
         line_ob_d = (state_q == OB_LINE) | ((state_q == WAIT_FV) & fv_rise);

      case (state_q)
         WAIT_FV: begin
            if (fv_rise) begin
               state_d    = OB_LINE;
               acc_d      = lv_in ? ACC_W'(data_in) : '0;
               pix_cnt_d  = lv_in ? PIX_W'(1) : '0;
               line_cnt_d = '0;
               meas_ok_d  = 1'b0;
               short_d    = 1'b0;
               armed_d    = 1'b1;
            end
         end
         OB_LINE: begin
            if (lv_in && pix_cnt_q < PIX_W'(OB_N)) begin
               acc_d     = acc_q + ACC_W'(data_in);
               pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
            if (lv_fall) begin
               short_now  = short_q | (pix_cnt_q < PIX_W'(OB_N));
               short_d    = short_now;
               line_cnt_d = line_cnt_q + LINE_W'(1);
               pix_cnt_d  = '0;
               if (line_cnt_q == LINE_W'(OB_LINES - 1)) begin
                  meas_ok_d = ~short_now;
                  state_d   = fv_fall ? UPDATE : ACTIVE;
               end else if (fv_fall) begin
                  state_d = WAIT_FV;
               end
            end else if (fv_fall) begin
               state_d = WAIT_FV;
            end
         end
         ACTIVE: begin
            if (fv_fall) state_d = UPDATE;
         end
         UPDATE: begin
            if (meas_ok_q) begin
               bl_d       = bl_new[12] ? 12'd0 : bl_new[11:0];
               bl_valid_d = 1'b1;
            end
            state_d = WAIT_FV;
         end
         default: state_d = WAIT_FV;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= WAIT_FV;
         data_s1_q  <= '0;
         fv_s1_q    <= 1'b0;
         lv_s1_q    <= 1'b0;
         prime_q    <= 1'b0;
         data_out_q <= '0;
         fv_out_q   <= 1'b0;
         lv_out_q   <= 1'b0;
         bl_q       <= DEFAULT_BL;
         bl_valid_q <= 1'b0;
         line_cnt_q <= '0;
         pix_cnt_q  <= '0;
         acc_q      <= '0;
         armed_q    <= 1'b0;
         meas_ok_q  <= 1'b0;
         short_q    <= 1'b0;
         line_ob_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_s1_q  <= data_s1_d;
         fv_s1_q    <= fv_s1_d;
         lv_s1_q    <= lv_s1_d;
         prime_q    <= prime_d;
         data_out_q <= data_out_d;
         fv_out_q   <= fv_out_d;
         lv_out_q   <= lv_out_d;
         bl_q       <= bl_d;
         bl_valid_q <= bl_valid_d;
         line_cnt_q <= line_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         acc_q      <= acc_d;
         armed_q    <= armed_d;
         meas_ok_q  <= meas_ok_d;
         short_q    <= short_d;
         line_ob_q  <= line_ob_d;
      end
   end

   assign data_out = data_out_q;
   assign fv_out   = fv_out_q;
   assign lv_out   = lv_out_q;
   assign bl_value = bl_q;
   assign bl_valid = bl_valid_q;

endmodule

// File: tb/tb_black_level_corr.sv
// Randomized frame-level bench for black_level_corr; two instances (filter shift 2 and 0)
// share stimulus and are checked against a per-frame arithmetic model.
module tb_black_level_corr;

   localparam int OB_LINES = 4;
   localparam int OB_PIX   = 256;
   localparam int DEF_BL   = 64;

   logic        clk = 1'b0;
   logic        rstn;
   logic [11:0] data_in;
   logic        fv_in, lv_in;
   logic [11:0] data_out, bl_value, data_out_f0, bl_value_f0;
   logic        fv_out, lv_out, bl_valid, fv_out_f0, lv_out_f0, bl_valid_f0;

   always #5 clk = ~clk;

   black_level_corr dut (
      .clk(clk), .rstn(rstn), .data_in(data_in), .fv_in(fv_in), .lv_in(lv_in),
      .data_out(data_out), .fv_out(fv_out), .lv_out(lv_out),
      .bl_value(bl_value), .bl_valid(bl_valid)
   );

   black_level_corr #(.FILT_SHIFT(0)) dut_f0 (
      .clk(clk), .rstn(rstn), .data_in(data_in), .fv_in(fv_in), .lv_in(lv_in),
      .data_out(data_out_f0), .fv_out(fv_out_f0), .lv_out(lv_out_f0),
      .bl_value(bl_value_f0), .bl_valid(bl_valid_f0)
   );

   typedef struct {int d0; int d1; bit fv; bit lv;} exp_t;

   exp_t q[$];
   int   pat[$];
   int   n_chk = 0, n_fail = 0;
   int   bl0, bl1;          // model black level, filter shift 2 and 0
   bit   v0, v1, armed_m, rst_seen, lv_prev;
   int   pulses;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sub_clip(input int d, input int bl);
      return (d > bl) ? d - bl : 0;
   endfunction

   // one pixel clock: drive inputs, record what must appear two clocks later
   task automatic cyc(input bit f, input bit l, input int d, input bit act);
      exp_t e;
      fv_in = f; lv_in = l; data_in = d[11:0];
      if (!rstn) begin
         bl0 = DEF_BL; bl1 = DEF_BL; v0 = 0; v1 = 0; armed_m = 0; rst_seen = 1;
         q.delete();
         e = '{0, 0, 1'b0, 1'b0};
      end else begin
         e = '{sub_clip(d, bl0), sub_clip(d, bl1), f & armed_m, l & armed_m & act};
      end
      q.push_back(e);
      @(posedge clk); #1;
      if (!rstn) begin
         chk("rst_data", data_out, 0);
         chk("rst_fv", fv_out, 0);
         chk("rst_lv", lv_out, 0);
         chk("rst_bl", bl_value, DEF_BL);
         chk("rst_blv", bl_valid, 0);
      end else if (q.size() >= 2) begin
         e = q.pop_front();
         chk("data", data_out, e.d0);
         chk("fv_out", fv_out, e.fv);
         chk("lv_out", lv_out, e.lv);
         chk("data_f0", data_out_f0, e.d1);
         chk("fv_out_f0", fv_out_f0, e.fv);
         chk("lv_out_f0", lv_out_f0, e.lv);
      end
      if (lv_out && !lv_prev) pulses++;
      lv_prev = lv_out;
   endtask

   // n_ob lines of OB, optional short line, n_act active lines, OB pixel values in [lo,hi];
   // rst_ln >= 0 pulses reset in the middle of that active line
   task automatic frame(input int n_ob, input int short_ln, input int n_act,
                        input int lo, input int hi, input int rst_ln);
      int sum, len, v, meas;
      bit ok;
      sum = 0; rst_seen = 0; pulses = 0;
      ok = (n_ob >= OB_LINES) && (short_ln < 0);
      armed_m = 1;
      repeat (4) cyc(1, 0, 0, 0);
      for (int ln = 0; ln < n_ob; ln++) begin
         len = (ln == short_ln) ? 100 : OB_PIX + $urandom_range(0, 4);
         for (int p = 0; p < len; p++) begin
            v = $urandom_range(lo, hi);
            if (p < OB_PIX && ln < OB_LINES) sum += v;
            cyc(1, 1, v, 0);
         end
         repeat (4) cyc(1, 0, 0, 0);
      end
      for (int ln = 0; ln < n_act; ln++) begin
         len = (ln == rst_ln) ? 10 : $urandom_range(4, 12);
         for (int p = 0; p < len; p++) begin
            v = (ln == 0 && p < pat.size()) ? pat[p] : $urandom_range(0, 4095);
            if (ln == rst_ln && p == 2) rstn = 0;
            if (ln == rst_ln && p == 4) rstn = 1;
            cyc(1, 1, v, 1);
         end
         repeat (4) cyc(1, 0, 0, 0);
      end
      repeat (2) cyc(1, 0, 0, 0);
      repeat (8) cyc(0, 0, 0, 0);
      if (ok && !rst_seen) begin
         meas = sum / 1024;
         if (meas > 512) meas = 512;
         bl0 = bl0 + ((meas - bl0) >>> 2);
         bl1 = meas;
         v0 = 1; v1 = 1;
      end
      chk("bl_value", bl_value, bl0);
      chk("bl_valid", bl_valid, v0);
      chk("bl_value_f0", bl_value_f0, bl1);
      chk("bl_valid_f0", bl_valid_f0, v1);
      if (rst_ln < 0) chk("lv_pulses", pulses, n_act);
      pat.delete();
   endtask

   initial begin
      int lo;
      rstn = 0; fv_in = 0; lv_in = 0; data_in = 0; lv_prev = 0;
      bl0 = DEF_BL; bl1 = DEF_BL; v0 = 0; v1 = 0; armed_m = 0;
      repeat (4) cyc(0, 0, 0, 0);
      rstn = 1;
      repeat (6) cyc(0, 0, 0, 0);

      pat = '{1000, 50, 4095};
      frame(4, -1, 10, 80, 80, -1);
      chk("bl_f1", bl_value, 68);
      chk("blv_f1", bl_valid, 1);
      chk("bl_f1_f0", bl_value_f0, 80);

      pat = '{1000};
      frame(4, -1, 3, 80, 80, -1);
      chk("bl_f2", bl_value, 71);

      frame(4, -1, 3, 600, 600, -1);
      chk("bl_clamp_f0", bl_value_f0, 512);

      frame(2, -1, 0, 300, 300, -1);
      frame(4, 1, 2, 300, 300, -1);
      frame(4, -1, 2, 0, 0, -1);

      repeat (4) begin
         lo = $urandom_range(0, 700);
         frame(4, -1, $urandom_range(1, 4), lo, lo + $urandom_range(0, 60), -1);
      end

      frame(4, -1, 5, 200, 200, 2);
      chk("bl_after_rst", bl_value, DEF_BL);
      chk("blv_after_rst", bl_valid, 0);

      pat = '{1000};
      frame(4, -1, 3, 200, 200, -1);
      chk("bl_post_rst", bl_value, 98);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
